// File: rtl/fir_pkg.sv
// Shared constants and types for the 64-tap time-shared FIR filter.
package fir_pkg;

  localparam int TAPS     = 64;
  localparam int SAMPLE_W = 16;
  localparam int COEF_W   = 16;
  localparam int ACC_W    = 38;
  localparam int IDX_W    = $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  typedef logic signed [COEF_W-1:0] coef_array_t [TAPS];

  // Tap weights h[0]..h[63]; h[0] multiplies the newest sample.
  localparam coef_array_t FIR_COEFFS = '{
    16'sd120,    -16'sd340,   16'sd512,    16'sd87,     -16'sd1023,  16'sd2048,   -16'sd77,    16'sd301,
    -16'sd4096,  16'sd1500,   16'sd33,     -16'sd990,   16'sd7777,   -16'sd250,   16'sd640,    -16'sd12,
    16'sd32767,  -16'sd32000, 16'sd5,      -16'sd5,     16'sd999,    16'sd1234,   -16'sd2222,  16'sd450,
    16'sd18000,  -16'sd9000,  16'sd300,    16'sd64,     -16'sd64,    16'sd2500,   -16'sd1800,  16'sd700,
    -16'sd15000, 16'sd12000,  16'sd8,      -16'sd8,     16'sd1111,   -16'sd4444,  16'sd3333,   16'sd16,
    16'sd255,    -16'sd256,   16'sd4000,   -16'sd3000,  16'sd2000,   -16'sd1000,  16'sd500,    -16'sd100,
    16'sd25000,  16'sd10,     -16'sd20000, 16'sd7,      16'sd6000,   -16'sd6000,  16'sd1,      -16'sd1,
    16'sd42,     -16'sd42,    16'sd900,    -16'sd900,   16'sd13000,  -16'sd13,    16'sd77,     -16'sd31000
  };

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate: acc += sample * coef each enabled cycle.
// 'sum' is the accumulator plus the current product, so the owner can capture
// the finished total on the same edge that adds the last tap.
module fir_mac
  import fir_pkg::*;
#(
  parameter int SampleWidth = SAMPLE_W,
  parameter int CoefWidth   = COEF_W,
  parameter int AccWidth    = ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [SampleWidth-1:0] sample,
  input  logic signed [CoefWidth-1:0]   coef,
  output logic signed [AccWidth-1:0]    sum
);

  localparam int ProdWidth = SampleWidth + CoefWidth;

  logic signed [ProdWidth-1:0] product;
  logic signed [AccWidth-1:0]  acc;

  // Operands are widened first so the full signed product is kept.
  assign product = ProdWidth'(sample) * ProdWidth'(coef);
  assign sum     = acc + {{(AccWidth - ProdWidth){product[ProdWidth-1]}}, product};

  // Accumulator: cleared on a new sample, otherwise adds one tap per enabled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/my_fir.sv
// 64-tap direct-form FIR with a single time-shared MAC (one tap per clock).
// Handshake: a sample is taken on any rising edge where inputValid=1 and the
// filter is in IDLE or DONE; inputValid is ignored while computing. The result
// appears 64 edges later with outputValid high for exactly one cycle, and
// FIR_output holds that value until the next result.
module my_fir
  import fir_pkg::*;
#(
  parameter int          InputWidth  = SAMPLE_W,
  parameter int          OutputWidth = ACC_W,
  parameter coef_array_t Coeffs      = FIR_COEFFS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inputValid,
  input  logic signed [InputWidth-1:0]  FIR_input,
  output logic                          outputValid,
  output logic signed [OutputWidth-1:0] FIR_output
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(TAPS - 1);

  fir_state_e                    state;
  logic [IDX_W-1:0]              idx;
  logic signed [InputWidth-1:0]  delay_line [TAPS];
  logic                          accept;
  logic                          mac_en;
  logic signed [InputWidth-1:0]  cur_sample;
  logic signed [COEF_W-1:0]      cur_coef;
  logic signed [OutputWidth-1:0] mac_sum;

  assign accept     = inputValid && (state != MAC);
  assign mac_en     = (state == MAC);
  assign cur_sample = delay_line[idx];
  assign cur_coef   = Coeffs[idx];

  // Delay line: newest sample at position 0, shifted only on an accepted sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) delay_line[i] <= '0;
    end else if (accept) begin
      delay_line[0] <= FIR_input;
      for (int i = 1; i < TAPS; i++) delay_line[i] <= delay_line[i-1];
    end
  end

  // Control FSM: tap index, result register and the one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      FIR_output  <= '0;
      outputValid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          outputValid <= 1'b0;
          if (inputValid) begin
            idx   <= '0;
            state <= MAC;
          end else begin
            state <= IDLE;
          end
        end
        MAC: begin
          if (idx == LastIdx) begin
            FIR_output  <= mac_sum;
            outputValid <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          outputValid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  fir_mac #(
    .SampleWidth(InputWidth),
    .CoefWidth  (COEF_W),
    .AccWidth   (OutputWidth)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (mac_en),
    .sample(cur_sample),
    .coef  (cur_coef),
    .sum   (mac_sum)
  );

endmodule

// File: tb/tb_my_fir.sv
// Self-checking bench for my_fir: behavioural convolution model over a queue
// of accepted samples, plus a second instance with all-minimum coefficients.
module tb_my_fir;
  import fir_pkg::*;

  localparam int NT = 64;
  localparam int H_REF [NT] = '{
    120, -340, 512, 87, -1023, 2048, -77, 301,
    -4096, 1500, 33, -990, 7777, -250, 640, -12,
    32767, -32000, 5, -5, 999, 1234, -2222, 450,
    18000, -9000, 300, 64, -64, 2500, -1800, 700,
    -15000, 12000, 8, -8, 1111, -4444, 3333, 16,
    255, -256, 4000, -3000, 2000, -1000, 500, -100,
    25000, 10, -20000, 7, 6000, -6000, 1, -1,
    42, -42, 900, -900, 13000, -13, 77, -31000
  };
  localparam coef_array_t EXT_COEFFS = '{default: 16'sh8000};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               inputValid = 1'b0;
  logic signed [15:0] FIR_input  = '0;
  logic               outputValid;
  logic signed [37:0] FIR_output;

  logic               ext_valid_in = 1'b0;
  logic signed [15:0] ext_input    = '0;
  logic               ext_valid_out;
  logic signed [37:0] ext_output;

  my_fir u_dut (
    .clk        (clk),
    .rst        (rst),
    .inputValid (inputValid),
    .FIR_input  (FIR_input),
    .outputValid(outputValid),
    .FIR_output (FIR_output)
  );

  my_fir #(.Coeffs(EXT_COEFFS)) u_ext (
    .clk        (clk),
    .rst        (rst),
    .inputValid (ext_valid_in),
    .FIR_input  (ext_input),
    .outputValid(ext_valid_out),
    .FIR_output (ext_output)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // ---------------- reference model ----------------
  int hist[$];  // accepted samples, newest first

  function automatic logic signed [37:0] model_y();
    longint acc = 0;
    for (int k = 0; k < hist.size(); k++) acc += longint'(H_REF[k]) * longint'(hist[k]);
    return 38'(acc);
  endfunction

  // ---------------- driver ----------------
  // Called #1 after an edge with the DUT in IDLE or DONE; returns #1 after
  // the edge that should raise outputValid.
  task automatic run_sample(input logic signed [15:0] s, input bit busy, input string tag);
    logic signed [37:0] exp_y;
    logic signed [37:0] prev_out;
    bit early;
    bit changed;
    hist.push_front(int'(s));
    if (hist.size() > NT) void'(hist.pop_back());
    exp_y    = model_y();
    prev_out = FIR_output;
    FIR_input  = s;
    inputValid = 1'b1;
    @(posedge clk); #1;
    inputValid = 1'b0;
    early   = 1'b0;
    changed = 1'b0;
    for (int c = 1; c <= NT; c++) begin
      if (busy) begin
        inputValid = (c % 2 == 1);
        FIR_input  = 16'($urandom);
      end
      @(posedge clk); #1;
      if (c < NT && outputValid !== 1'b0) early = 1'b1;
      if (c < NT && FIR_output !== prev_out) changed = 1'b1;
    end
    inputValid = 1'b0;
    n_compared++;
    if (early !== 1'b0) begin
      n_mismatched++;
      $display("FAIL %s early_valid: outputValid rose before 64 edges, required low", tag);
    end
    n_compared++;
    if (changed !== 1'b0) begin
      n_mismatched++;
      $display("FAIL %s hold_during_mac: FIR_output changed during MAC, required %0d", tag, prev_out);
    end
    n_compared++;
    if (outputValid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL %s valid_at_64: outputValid=%b required 1", tag, outputValid);
    end
    n_compared++;
    if (FIR_output !== exp_y) begin
      n_mismatched++;
      $display("FAIL %s result: FIR_output=%0d required %0d", tag, FIR_output, exp_y);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_compared++;
    if (outputValid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_valid: outputValid=%b required 0", outputValid);
    end
    n_compared++;
    if (FIR_output !== 38'sd0) begin
      n_mismatched++;
      $display("FAIL reset_output: FIR_output=%0d required 0", FIR_output);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    hist.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    run_sample(16'sd1, 1'b0, "impulse_0");
    for (int i = 1; i < NT; i++) run_sample(16'sd0, 1'b0, $sformatf("impulse_%0d", i));
  endtask

  task automatic test_latency_hold();
    logic signed [37:0] exp_y;
    repeat (3) @(posedge clk); #1;
    run_sample(16'($urandom), 1'b0, "latency");
    exp_y = model_y();
    @(posedge clk); #1;
    n_compared++;
    if (outputValid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL latency_single_pulse: outputValid=%b required 0", outputValid);
    end
    repeat (5) @(posedge clk); #1;
    n_compared++;
    if (outputValid !== 1'b0 || FIR_output !== exp_y) begin
      n_mismatched++;
      $display("FAIL idle_hold: valid=%b out=%0d required valid 0 out %0d", outputValid, FIR_output, exp_y);
    end
  endtask

  task automatic test_busy();
    for (int i = 0; i < 8; i++)
      run_sample(16'($urandom), (i % 2 == 1), $sformatf("busy_%0d", i));
  endtask

  task automatic test_reset_mid_mac();
    bit saw_valid;
    FIR_input  = 16'sd1234;
    inputValid = 1'b1;
    @(posedge clk); #1;
    inputValid = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_compared++;
    if (FIR_output !== 38'sd0 || outputValid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL mid_mac_reset: out=%0d valid=%b required 0 and 0", FIR_output, outputValid);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    hist.delete();
    saw_valid = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (outputValid !== 1'b0) saw_valid = 1'b1;
    end
    n_compared++;
    if (saw_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL aborted_pulse: outputValid seen after abort, required none");
    end
    run_sample(16'sd1, 1'b0, "post_reset_h0");
    run_sample(16'sd0, 1'b0, "post_reset_h1");
  endtask

  task automatic test_extremes();
    logic signed [37:0] exp_y;
    for (int n = 1; n <= NT; n++) begin
      ext_input    = 16'sh8000;
      ext_valid_in = 1'b1;
      @(posedge clk); #1;
      ext_valid_in = 1'b0;
      repeat (NT) @(posedge clk);
      #1;
      exp_y = 38'(longint'(n) * 64'sd1073741824);
      n_compared++;
      if (ext_valid_out !== 1'b1 || ext_output !== exp_y) begin
        n_mismatched++;
        $display("FAIL extreme_%0d: valid=%b out=%0d required 1 and %0d", n, ext_valid_out, ext_output, exp_y);
      end
    end
    n_compared++;
    if (ext_output !== 38'sd68719476736) begin
      n_mismatched++;
      $display("FAIL extreme_final: out=%0d required 68719476736", ext_output);
    end
  endtask

  task automatic test_stream();
    logic signed [15:0] s;
    for (int i = 0; i < 1000; i++) begin
      s = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
      run_sample(s, 1'b0, $sformatf("stream_%0d", i));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_impulse();
    test_latency_hold();
    test_busy();
    test_reset_mid_mac();
    test_extremes();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/my_fir.md
MY_FIR -- requirements
Module: my_fir

Interface
REQ-001 Parameter InputWidth, default 16, sample width (signed two's complement).
REQ-002 Parameter OutputWidth, default 38, result width (signed two's complement).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-low reset.
REQ-005 Port inputValid, input, 1, FIR_input holds a new sample this cycle.
REQ-006 Port FIR_input, input, InputWidth, signed input sample.
REQ-007 Port outputValid, output, 1, one-cycle pulse marking a new FIR_output.
REQ-008 Port FIR_output, output, OutputWidth, signed filter result, registered.

Function
REQ-009 The block SHALL implement a 64-tap direct-form FIR: y[n] = sum over k=0..63 of h[k]*x[n-k].
- h[k] are 16-bit signed constants.
- x samples older than the first accepted sample are 0.
REQ-010 The block SHALL use one time-shared multiply-accumulate, one tap per clock.
REQ-011 The FSM SHALL have states IDLE, MAC and DONE.
REQ-012 In IDLE or DONE, inputValid=1 at a rising edge SHALL perform all of the following on that edge:
- shift FIR_input into delay-line position 0 (oldest sample discarded);
- clear the accumulator and tap index;
- enter MAC.
REQ-013 In MAC, each edge SHALL add x[idx]*h[idx] (full 32-bit signed product, sign-extended) to a 38-bit accumulator and increment idx.
- After the idx=63 product, the state SHALL move to DONE and the complete sum SHALL be loaded into FIR_output.
REQ-014 outputValid SHALL be 1 exactly during the DONE cycle.
- Latency: the accept edge is edge T; outputValid is high from edge T+64 to edge T+65.
REQ-015 DONE with inputValid=0 SHALL return to IDLE; outputValid SHALL never be high two consecutive cycles without a new accept.
REQ-016 inputValid during MAC SHALL be ignored: no sample captured, result unaffected.
REQ-017 FIR_output SHALL hold its last value until the next DONE.
REQ-018 Arithmetic SHALL be signed with no saturation or rounding.
- The 38-bit width holds the worst case 64*2^30, so overflow cannot occur.
REQ-019 Maximum throughput SHALL be one sample per 65 clocks, with inputValid asserted in the DONE cycle.

Reset
REQ-020 rst=0 SHALL asynchronously force the following, regardless of state:
- state = IDLE;
- delay line, accumulator and idx = 0;
- FIR_output = 0;
- outputValid = 0.
REQ-021 Reset during MAC SHALL abort the computation with no outputValid pulse; the first accept after release starts from a zeroed history.

Structure
REQ-022 A shared package fir_pkg SHALL hold:
- TAPS = 64;
- sample, coefficient and accumulator widths;
- the 64-entry signed coefficient constant array.
REQ-023 One sub-module, fir_mac, SHALL hold the registered 16x16 signed multiply-add into the 38-bit accumulator; the delay line, FSM and index counter stay in my_fir.

Verification
REQ-024 Impulse: after reset, accept 1 then 63 zeros, each accepted in DONE -> 64 outputs equal h[0]..h[63] in order.
REQ-025 Latency: accept at edge T -> outputValid high only between edges T+64 and T+65, exactly one cycle.
REQ-026 Extremes: 64 samples of -32768 with all h[k] = -32768 -> final FIR_output = 2^36 = 68719476736, with no sign error.
REQ-027 Busy input: toggle inputValid every cycle during MAC -> result identical to a clean run, and one outputValid per accept.
REQ-028 Reset mid-MAC: assert rst at MAC cycle 30 -> FIR_output = 0 and outputValid = 0 immediately; the next impulse reproduces h[0].
REQ-029 Stream: 1000 random signed samples vs. a golden model -> every FIR_output matches bit-exactly.
